// File: rtl/hex_oled_stream.sv
// Streams a multi-field hex snapshot of din to a UART as OLED text frames:
// a home escape, a settle delay, then the hex digits with optional separators.
//
// state | meaning
// IDLE  | between frames; waits for a trigger when ONCHANGE=1
// SNAP  | capture din, clear the pending refresh
// HDR   | send ESC 'G' '@' '@'
// WAIT  | DELAY silent cycles for the display to home
// DATA  | send one hex character per nibble
// SEPC  | send SEP between fields
// DONE  | frame_done pulse
module hex_oled_stream #(
  parameter int          NFIELD   = 4,
  parameter int          DIGITS   = 8,
  parameter int          DELAY    = 65535,
  parameter logic [7:0]  SEP      = 8'h00,
  parameter int          ONCHANGE = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NFIELD*DIGITS*4-1:0] din,
  input  logic                       refresh,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       frame_done,
  output logic                       active
);

  localparam int W   = NFIELD * DIGITS * 4;
  localparam int NCH = NFIELD * DIGITS;
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW  = (NFIELD > 1) ? $clog2(NFIELD) : 1;
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
  localparam logic [FW-1:0] FLD_LAST = FW'(NFIELD - 1);
  localparam logic [15:0]   DLY_LOAD = 16'(DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_HDR, S_WAIT, S_DATA, S_SEPC, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      hdr_cnt;
  logic [15:0]     dly_cnt;
  logic [DW-1:0]   dig;
  logic [FW-1:0]   fld;
  logic [W-1:0]    snap;
  logic            pending;
  logic            first_frame;
  logic [3:0]      nib;
  logic [7:0]      hex_char;

  // Character k counts from the MSB end of the snapshot: field 0, MSB nibble first.
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < NCH; k++) begin
      if (k == int'(fld) * DIGITS + int'(dig)) nib = snap[W-1-4*k -: 4];
    end
  end

  assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;
    active     = 1'b1;
    case (state)
      S_IDLE: begin
        active = 1'b0;
        if (ONCHANGE == 0 || din != snap || pending || first_frame) state_nxt = S_SNAP;
      end
      S_SNAP: state_nxt = S_HDR;
      S_HDR: begin
        tx_valid = 1'b1;
        case (hdr_cnt)
          2'd0:    tx_data = 8'h1B;
          2'd1:    tx_data = 8'h47;
          default: tx_data = 8'h40;
        endcase
        if (tx_ready && hdr_cnt == 2'd3) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dly_cnt == 16'd0) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = hex_char;
        if (tx_ready && dig == DIG_LAST) begin
          if (fld == FLD_LAST)   state_nxt = S_DONE;
          else if (SEP != 8'h00) state_nxt = S_SEPC;
        end
      end
      S_SEPC: begin
        tx_valid = 1'b1;
        tx_data  = SEP;
        if (tx_ready) state_nxt = S_DATA;
      end
      S_DONE: begin
        frame_done = 1'b1;
        active     = 1'b0;
        state_nxt  = S_IDLE;
      end
      default: begin
        active    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hdr_cnt     <= 2'd0;
      dly_cnt     <= 16'd0;
      dig         <= '0;
      fld         <= '0;
      snap        <= '0;
      pending     <= 1'b0;
      first_frame <= 1'b1;
    end else begin
      // A refresh landing in SNAP is served by the frame being captured.
      if (state == S_SNAP) begin
        snap        <= din;
        pending     <= 1'b0;
        first_frame <= 1'b0;
        hdr_cnt     <= 2'd0;
        dig         <= '0;
        fld         <= '0;
      end else if (refresh && ONCHANGE != 0) begin
        pending <= 1'b1;
      end

      if (state == S_HDR && tx_ready) hdr_cnt <= hdr_cnt + 2'd1;

      if (state == S_HDR && tx_ready && hdr_cnt == 2'd3) dly_cnt <= DLY_LOAD;
      else if (state == S_WAIT && dly_cnt != 16'd0)      dly_cnt <= dly_cnt - 16'd1;

      if (state == S_DATA && tx_ready) begin
        if (dig == DIG_LAST) begin
          dig <= '0;
          if (fld != FLD_LAST) fld <= fld + 1'b1;
        end else begin
          dig <= dig + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_oled_stream.sv
// Self-checking bench for hex_oled_stream: three configurations, table vectors,
// random data/back-pressure against a frame-level model, and reset/refresh corners.
module tb_hex_oled_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: 2x4 digits, DELAY 3, space separator, continuous
  logic        rstn_a, refresh_a, ready_a, valid_a, done_a, active_a;
  logic [31:0] din_a;
  logic [7:0]  data_a;
  // B: same layout, on-change mode
  logic        rstn_b, refresh_b, ready_b, valid_b, done_b, active_b;
  logic [31:0] din_b;
  logic [7:0]  data_b;
  // C: single digit, DELAY 2
  logic        rstn_c, refresh_c, ready_c, valid_c, done_c, active_c;
  logic [3:0]  din_c;
  logic [7:0]  data_c;

  hex_oled_stream #(.NFIELD(2), .DIGITS(4), .DELAY(3), .SEP(8'h20), .ONCHANGE(0)) u_a (
    .clk(clk), .rstn(rstn_a), .din(din_a), .refresh(refresh_a), .tx_data(data_a),
    .tx_valid(valid_a), .tx_ready(ready_a), .frame_done(done_a), .active(active_a));

  hex_oled_stream #(.NFIELD(2), .DIGITS(4), .DELAY(3), .SEP(8'h20), .ONCHANGE(1)) u_b (
    .clk(clk), .rstn(rstn_b), .din(din_b), .refresh(refresh_b), .tx_data(data_b),
    .tx_valid(valid_b), .tx_ready(ready_b), .frame_done(done_b), .active(active_b));

  hex_oled_stream #(.NFIELD(1), .DIGITS(1), .DELAY(2), .SEP(8'h20), .ONCHANGE(0)) u_c (
    .clk(clk), .rstn(rstn_c), .din(din_c), .refresh(refresh_c), .tx_data(data_c),
    .tx_valid(valid_c), .tx_ready(ready_c), .frame_done(done_c), .active(active_c));

  int         sel = 0;
  logic       m_valid, m_ready, m_done, m_active;
  logic [7:0] m_data;

  always_comb begin
    m_valid = valid_a; m_ready = ready_a; m_done = done_a; m_active = active_a; m_data = data_a;
    case (sel)
      1: begin m_valid = valid_b; m_ready = ready_b; m_done = done_b; m_active = active_b; m_data = data_b; end
      2: begin m_valid = valid_c; m_ready = ready_c; m_done = done_c; m_active = active_c; m_data = data_c; end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] din;
    logic [71:0] chars;
  } vec_t;
  vec_t vecs[4];

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         gap;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference frame: header, then each nibble as a hex character, separator between fields.
  task automatic build_exp(input logic [127:0] d, input int nf, input int nd, input logic [7:0] sep);
    int n;
    logic [3:0] nb;
    n = nf * nd;
    exp_q = '{8'h1B, 8'h47, 8'h40, 8'h40};
    for (int c = 0; c < n; c++) begin
      nb = 4'(d >> (4 * (n - 1 - c)));
      if (nb < 10) exp_q.push_back(8'h30 + 8'(nb));
      else         exp_q.push_back(8'h41 + 8'(nb) - 8'd10);
      if ((c % nd) == nd - 1 && (c / nd) < nf - 1 && sep != 8'h00) exp_q.push_back(sep);
    end
  endtask

  task automatic capture_frame(input int budget, output bit ok);
    got_q.delete();
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_valid && m_ready)                 got_q.push_back(m_data);
      else if (!m_valid && got_q.size() == 4) gap++;
      if (m_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
  endtask

  task automatic reset_sel();
    case (sel)
      1:       rstn_b = 1'b0;
      2:       rstn_c = 1'b0;
      default: rstn_a = 1'b0;
    endcase
    repeat (2) @(posedge clk);
    #1;
    rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) ready_a = ($urandom_range(0, 3) != 0);
  end

  // A stalled byte must stay presented unchanged on the next cycle.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  initial forever begin
    @(negedge clk);
    if (prev_stall && rstn_a) begin
      check("hold_valid", valid_a, 1'b1);
      check("hold_data", data_a, prev_data);
    end
    prev_stall = valid_a && !ready_a && rstn_a;
    prev_data  = data_a;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int cnt;

    vecs[0] = '{32'h12AB_F00D, 72'h31_32_41_42_20_46_30_30_44};
    vecs[1] = '{32'h0000_0000, 72'h30_30_30_30_20_30_30_30_30};
    vecs[2] = '{32'hFFFF_FFFF, 72'h46_46_46_46_20_46_46_46_46};
    vecs[3] = '{32'h89AB_CDEF, 72'h38_39_41_42_20_43_44_45_46};

    rstn_a = 0; rstn_b = 0; rstn_c = 0;
    refresh_a = 0; refresh_b = 0; refresh_c = 0;
    ready_a = 1; ready_b = 1; ready_c = 1;
    din_a = 32'h0; din_b = 32'h1; din_c = 4'hC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_data_a", data_a, 8'h00);
    check("rst_done_a", done_a, 1'b0);
    check("rst_active_a", active_a, 1'b0);
    check("rst_valid_b", valid_b, 1'b0);
    check("rst_active_c", active_c, 1'b0);

    // table vectors, full-rate
    sel = 0;
    foreach (vecs[i]) begin
      din_a = vecs[i].din;
      reset_sel();
      exp_q = '{8'h1B, 8'h47, 8'h40, 8'h40};
      for (int j = 0; j < 9; j++) exp_q.push_back(vecs[i].chars[71-8*j -: 8]);
      capture_frame(200, ok);
      check("tbl_frame_end", ok, 1'b1);
      check("tbl_active_at_done", active_a, 1'b0);
      cmp_frame("tbl");
      check("tbl_gap", gap, 3);
    end
    capture_frame(200, ok);
    check("next_frame_end", ok, 1'b1);
    cmp_frame("next");

    // back-pressure on the "A" character
    din_a = 32'h12AB_F00D;
    reset_sel();
    build_exp(din_a, 2, 4, 8'h20);
    seen = 1'b0;
    fork
      capture_frame(300, ok);
      begin
        for (int i = 0; i < 100 && !seen; i++) begin
          @(posedge clk);
          #1;
          if (valid_a && data_a == 8'h41) seen = 1'b1;
        end
        check("stall_seen", seen, 1'b1);
        if (seen) begin
          ready_a = 1'b0;
          repeat (5) begin
            @(negedge clk);
            check("stall_valid", valid_a, 1'b1);
            check("stall_data", data_a, 8'h41);
          end
          @(posedge clk);
          #1;
          ready_a = 1'b1;
        end
      end
    join
    check("stall_frame_end", ok, 1'b1);
    cmp_frame("stall");

    // random data with random back-pressure
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      din_a = $urandom;
      reset_sel();
      build_exp(din_a, 2, 4, 8'h20);
      capture_frame(600, ok);
      check("rnd_frame_end", ok, 1'b1);
      cmp_frame("rnd");
      check("rnd_gap", gap, 3);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    ready_a = 1'b1;

    // reset during the data phase
    din_a = 32'h12AB_F00D;
    reset_sel();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (valid_a && data_a == 8'h32) seen = 1'b1;
    end
    check("abort_seen", seen, 1'b1);
    rstn_a = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", valid_a, 1'b0);
    check("abort_active", active_a, 1'b0);
    rstn_a = 1'b1;
    build_exp(din_a, 2, 4, 8'h20);
    capture_frame(200, ok);
    check("abort_frame_end", ok, 1'b1);
    check("abort_first", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h1B);
    cmp_frame("abort");

    // on-change mode
    sel = 1;
    din_b = 32'h0000_0001;
    reset_sel();
    build_exp(din_b, 2, 4, 8'h20);
    capture_frame(200, ok);
    check("oc_first_end", ok, 1'b1);
    cmp_frame("oc_first");
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (valid_b) cnt++;
    end
    check("oc_quiet", cnt, 0);
    din_b = 32'h0000_0002;
    build_exp(din_b, 2, 4, 8'h20);
    capture_frame(200, ok);
    check("oc_change_end", ok, 1'b1);
    cmp_frame("oc_change");
    check("oc_last_char", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'h00, 8'h32);

    // refresh before and during a frame: two frames total, then silence
    @(posedge clk);
    #1 refresh_b = 1'b1;
    @(posedge clk);
    #1 refresh_b = 1'b0;
    fork
      capture_frame(200, ok);
      begin
        repeat (8) @(posedge clk);
        #1 refresh_b = 1'b1;
        @(posedge clk);
        #1 refresh_b = 1'b0;
      end
    join
    check("oc_req_end", ok, 1'b1);
    cmp_frame("oc_req");
    capture_frame(200, ok);
    check("oc_pend_end", ok, 1'b1);
    cmp_frame("oc_pend");
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid_b) cnt++;
    end
    check("oc_pend_quiet", cnt, 0);

    // single-digit configuration
    sel = 2;
    din_c = 4'hC;
    reset_sel();
    exp_q = '{8'h1B, 8'h47, 8'h40, 8'h40, 8'h43};
    capture_frame(100, ok);
    check("c_frame_end", ok, 1'b1);
    cmp_frame("c_tbl");
    check("c_gap", gap, 2);
    for (int r = 0; r < 3; r++) begin
      din_c = 4'($urandom_range(0, 15));
      reset_sel();
      build_exp(din_c, 1, 1, 8'h20);
      capture_frame(100, ok);
      check("c_rnd_end", ok, 1'b1);
      cmp_frame("c_rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
